// File: rtl/s_aes_core_arbiter_if.sv
// Requester-side bundle of the S-AES core arbiter: per-requester request and response handshakes.
// The arbiter connects through the slave modport; requesters use the master modport.
interface s_aes_core_arbiter_if #(
   parameter int NUM_REQ = 2
);
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ*16-1:0] req_plaintext;
   logic [NUM_REQ*16-1:0] req_key;
   logic [NUM_REQ-1:0]    rsp_valid;
   logic [NUM_REQ-1:0]    rsp_ready;
   logic [15:0]           rsp_ciphertext;

   modport master (
      output req_valid, req_plaintext, req_key, rsp_ready,
      input  req_ready, rsp_valid, rsp_ciphertext
   );

   modport slave (
      input  req_valid, req_plaintext, req_key, rsp_ready,
      output req_ready, rsp_valid, rsp_ciphertext
   );
endinterface

// File: rtl/s_aes_core_arbiter.sv
// Round-robin arbiter that time-shares one S-AES core among NUM_REQ requesters.
// Core inputs are registered, held for CORE_LAT cycles, and the ciphertext is returned to the owner.
module s_aes_core_arbiter #(
   parameter int NUM_REQ  = 2,
   parameter int CORE_LAT = 1,
   parameter int IDW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   s_aes_core_arbiter_if.slave  bus,
   output logic [15:0]          core_plaintext,
   output logic [15:0]          core_initialkey,
   input  logic [15:0]          core_ciphertext,
   output logic                 busy,
   output logic [IDW-1:0]       owner
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [IDW-1:0]     rr_ptr_q;
   logic [IDW-1:0]     owner_q;
   logic [IDW-1:0]     gnt;
   logic [IDW-1:0]     gnt_next;
   logic               any_valid;
   logic [3:0]         cnt_q;
   logic [15:0]        core_pt_q;
   logic [15:0]        core_key_q;
   logic [15:0]        rsp_ct_q;
   logic [NUM_REQ-1:0] rsp_valid_q;
   logic [NUM_REQ-1:0] req_ready_d;
   logic [15:0]        pt_arr  [NUM_REQ];
   logic [15:0]        key_arr [NUM_REQ];

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         pt_arr[i]  = bus.req_plaintext[16*i +: 16];
         key_arr[i] = bus.req_key[16*i +: 16];
      end
   end

   // Rotating priority scan: first valid requester at or after rr_ptr wins.
   always_comb begin
      int             idx;
      logic [IDW-1:0] cand;
      // NOTE: every variable written here gets a default first so no latch is inferred.
      gnt       = '0;
      any_valid = 1'b0;
      idx       = 0;
      cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         cand = idx[IDW-1:0];
         if (!any_valid && bus.req_valid[cand]) begin
            any_valid = 1'b1;
            gnt       = cand;
         end
      end
      gnt_next = (gnt == IDW'(NUM_REQ - 1)) ? '0 : gnt + IDW'(1);
   end

   // Gated by rst_n so that req_ready reads 0 while reset is held, even with requests pending.
   always_comb begin
      req_ready_d = '0;
      if (state_q == IDLE && any_valid && rst_n) req_ready_d[gnt] = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_valid) state_d = ISSUE;
         ISSUE:   if (cnt_q == 4'd0) state_d = RESP;
         RESP:    if (bus.rsp_ready[owner_q]) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         cnt_q       <= 4'd0;
         core_pt_q   <= 16'd0;
         core_key_q  <= 16'd0;
         rsp_ct_q    <= 16'd0;
         rsp_valid_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (any_valid) begin
                  core_pt_q  <= pt_arr[gnt];
                  core_key_q <= key_arr[gnt];
                  owner_q    <= gnt;
                  rr_ptr_q   <= gnt_next;
                  cnt_q      <= 4'(CORE_LAT - 1);
               end
            end
            ISSUE: begin
               if (cnt_q != 4'd0) begin
                  cnt_q <= cnt_q - 4'd1;
               end else begin
                  rsp_ct_q             <= core_ciphertext;
                  rsp_valid_q[owner_q] <= 1'b1;
               end
            end
            RESP: begin
               if (bus.rsp_ready[owner_q]) rsp_valid_q <= '0;
            end
            default: ;
         endcase
      end
   end

   assign bus.req_ready      = req_ready_d;
   assign bus.rsp_valid      = rsp_valid_q;
   assign bus.rsp_ciphertext = rsp_ct_q;
   assign core_plaintext     = core_pt_q;
   assign core_initialkey    = core_key_q;
   assign busy               = (state_q != IDLE);
   assign owner              = owner_q;

endmodule
